// File: rtl/psum_accum_buf.sv
// rtl/psum_accum_buf.sv - partial-sum accumulation buffer with RMW pipeline, quantisation and readout
//
// Purpose: holds a depth x col array of signed psums. Each accepted request does a
// pipelined read-modify-write of one row (accumulate or overwrite, per-column mask,
// saturating add). The updated row is presented two cycles later together with its
// ReLU + shift quantised activations. A side port reads rows back when the update
// path is idle. A clear FSM sweeps the whole array to zero after reset or on request.
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   clr_i / busy_o          clear request (honoured only on an idle RUN cycle) / sweep in progress
//   in_valid_i / in_ready_o request handshake
//   in_acc_i, in_mask_i     accumulate vs overwrite, per-column write enable
//   in_addr_i, in_psum_i    target row, new psums (col i at [psum_bw*i +: psum_bw])
//   out_valid_o, out_addr_o updated-row pulse and its row address
//   out_psum_o, out_act_o   full updated row and its quantised activations
//   rd_req_i, rd_addr_i     readout request / row
//   rd_ack_o                readout grant (combinational, update path has priority)
//   rd_valid_o, rd_data_o   readout result, one cycle after the grant
//   sat_cnt_o               saturation event counter (only with PSUM_ACCUM_BUF_STATS_EN)
//
// Optional feature macro: PSUM_ACCUM_BUF_STATS_EN

module psum_accum_buf #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int act_bw  = 4,
    parameter int depth   = 2048,
    parameter int addr_bw = 11,
    parameter int qshift  = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clr_i,
    output logic                   busy_o,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   in_acc_i,
    input  logic [col-1:0]         in_mask_i,
    input  logic [addr_bw-1:0]     in_addr_i,
    input  logic [psum_bw*col-1:0] in_psum_i,
    output logic                   out_valid_o,
    output logic [addr_bw-1:0]     out_addr_o,
    output logic [psum_bw*col-1:0] out_psum_o,
    output logic [act_bw*col-1:0]  out_act_o,
    input  logic                   rd_req_i,
    input  logic [addr_bw-1:0]     rd_addr_i,
    output logic                   rd_ack_o,
    output logic                   rd_valid_o,
`ifdef PSUM_ACCUM_BUF_STATS_EN
    output logic [15:0]            sat_cnt_o,
`endif
    output logic [psum_bw*col-1:0] rd_data_o
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam logic [addr_bw-1:0]        LAST_ROW = addr_bw'(depth - 1);
    localparam logic signed [psum_bw-1:0] SAT_MAX  = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic signed [psum_bw-1:0] SAT_MIN  = {1'b1, {(psum_bw-1){1'b0}}};
    localparam logic signed [psum_bw-1:0] ACT_MAX  = psum_bw'((1 << act_bw) - 1);

    // FSM state and its registered decodes
    state_t               state_q;
    logic [addr_bw-1:0]   ptr_q;
    logic                 busy_q;
    logic                 ready_q;

    // Psum array
    logic [psum_bw*col-1:0] mem_q [depth];

    // S1: captured request plus the array row read at capture time
    logic                   s1_valid_q;
    logic                   s1_acc_q;
    logic [col-1:0]         s1_mask_q;
    logic [addr_bw-1:0]     s1_addr_q;
    logic [psum_bw*col-1:0] s1_psum_q;
    logic [psum_bw*col-1:0] s1_old_q;

    // S2: output registers, also the forwarding source
    logic                   out_valid_q;
    logic [addr_bw-1:0]     out_addr_q;
    logic [psum_bw*col-1:0] out_psum_q;
    logic [act_bw*col-1:0]  out_act_q;

    logic                   rd_valid_q;
    logic [psum_bw*col-1:0] rd_data_q;

    logic                   accept;
    logic                   rd_ack;
    logic                   clr_enter;
    logic                   fwd;
    logic [psum_bw*col-1:0] res_row_d;
    logic [act_bw*col-1:0]  act_row_d;
    logic [col-1:0]         col_sat_d;

    logic signed [psum_bw-1:0] old_c;
    logic signed [psum_bw-1:0] base_c;
    logic signed [psum_bw-1:0] add_c;
    logic signed [psum_bw:0]   sum_c;
    logic signed [psum_bw-1:0] clip_c;
    logic signed [psum_bw-1:0] res_c;
    logic signed [psum_bw-1:0] sh_c;

    logic                   wr_en;
    logic [addr_bw-1:0]     wr_addr;
    logic [psum_bw*col-1:0] wr_row;

    assign accept     = ready_q & in_valid_i;
    assign rd_ack     = ready_q & rd_req_i & ~in_valid_i;
    assign clr_enter  = ready_q & clr_i & ~in_valid_i;

    assign busy_o      = busy_q;
    assign in_ready_o  = ready_q;
    assign rd_ack_o    = rd_ack;
    assign out_valid_o = out_valid_q;
    assign out_addr_o  = out_addr_q;
    assign out_psum_o  = out_psum_q;
    assign out_act_o   = out_act_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;

    // The S1 array read happened at the same edge as the previous op's write, so
    // that write is invisible in s1_old_q; take the row from S2 instead.
    assign fwd = out_valid_q && (out_addr_q == s1_addr_q);

    always_comb begin
        res_row_d = '0;
        act_row_d = '0;
        col_sat_d = '0;
        old_c     = '0;
        base_c    = '0;
        add_c     = '0;
        sum_c     = '0;
        clip_c    = '0;
        res_c     = '0;
        sh_c      = '0;
        for (int i = 0; i < col; i++) begin
            old_c  = fwd ? out_psum_q[i*psum_bw +: psum_bw] : s1_old_q[i*psum_bw +: psum_bw];
            base_c = s1_acc_q ? old_c : '0;
            add_c  = s1_psum_q[i*psum_bw +: psum_bw];
            sum_c  = {base_c[psum_bw-1], base_c} + {add_c[psum_bw-1], add_c};
            // Sign of the extended sum disagrees with the truncated sign only on overflow
            if (sum_c[psum_bw] != sum_c[psum_bw-1]) begin
                clip_c       = sum_c[psum_bw] ? SAT_MIN : SAT_MAX;
                col_sat_d[i] = s1_valid_q & s1_mask_q[i];
            end else begin
                clip_c = sum_c[psum_bw-1:0];
            end
            res_c = s1_mask_q[i] ? clip_c : old_c;
            res_row_d[i*psum_bw +: psum_bw] = res_c;
            sh_c = res_c >>> qshift;
            if (sh_c < 0) begin
                act_row_d[i*act_bw +: act_bw] = '0;
            end else if (sh_c > ACT_MAX) begin
                act_row_d[i*act_bw +: act_bw] = '1;
            end else begin
                act_row_d[i*act_bw +: act_bw] = sh_c[act_bw-1:0];
            end
        end
    end

    // Single write port: the sweep owns it in CLEAR, the S1 op owns it in RUN
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_row  = '0;
        if (!reset_i) begin
            if (state_q == ST_CLEAR) begin
                wr_en   = 1'b1;
                wr_addr = ptr_q;
            end else begin
                wr_en   = s1_valid_q;
                wr_addr = s1_addr_q;
                wr_row  = res_row_d;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_row;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (ptr_q == LAST_ROW) begin
                        state_q <= ST_RUN;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                default: begin
                    if (clr_enter) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_valid_q  <= 1'b0;
            s1_acc_q    <= 1'b0;
            s1_mask_q   <= '0;
            s1_addr_q   <= '0;
            s1_psum_q   <= '0;
            s1_old_q    <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_psum_q  <= '0;
            out_act_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_acc_q  <= in_acc_i;
                s1_mask_q <= in_mask_i;
                s1_addr_q <= in_addr_i;
                s1_psum_q <= in_psum_i;
                s1_old_q  <= mem_q[in_addr_i];
            end
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_addr_q <= s1_addr_q;
                out_psum_q <= res_row_d;
                out_act_q  <= act_row_d;
            end
            rd_valid_q <= rd_ack;
            if (rd_ack) begin
                // Same-edge write to the requested row is returned directly
                rd_data_q <= (s1_valid_q && (s1_addr_q == rd_addr_i)) ? res_row_d : mem_q[rd_addr_i];
            end
        end
    end

`ifdef PSUM_ACCUM_BUF_STATS_EN
    logic [15:0] sat_cnt_q;
    logic [15:0] sat_add_c;
    logic [16:0] sat_sum_c;

    always_comb begin
        sat_add_c = '0;
        for (int i = 0; i < col; i++) begin
            sat_add_c = sat_add_c + 16'(col_sat_d[i]);
        end
        sat_sum_c = {1'b0, sat_cnt_q} + {1'b0, sat_add_c};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sat_cnt_q <= '0;
        end else if (clr_enter) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_sum_c[16] ? 16'hFFFF : sat_sum_c[15:0];
        end
    end

    assign sat_cnt_o = sat_cnt_q;
`endif

endmodule

// File: tb/tb_psum_accum_buf.sv
// tb/tb_psum_accum_buf.sv - scoreboard bench for psum_accum_buf with a row-level reference model
module tb_psum_accum_buf;

    localparam int COL = 8;
    localparam int PBW = 16;
    localparam int ABW = 4;
    localparam int DEP = 16;
    localparam int AW  = 4;
    localparam int QS  = 4;

    typedef struct {
        logic [AW-1:0]      addr;
        logic [PBW*COL-1:0] psum;
        logic [ABW*COL-1:0] act;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 clr = 1'b0;
    logic                 busy;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 in_acc = 1'b0;
    logic [COL-1:0]       in_mask = '0;
    logic [AW-1:0]        in_addr = '0;
    logic [PBW*COL-1:0]   in_psum = '0;
    logic                 out_valid;
    logic [AW-1:0]        out_addr;
    logic [PBW*COL-1:0]   out_psum;
    logic [ABW*COL-1:0]   out_act;
    logic                 rd_req = 1'b0;
    logic [AW-1:0]        rd_addr = '0;
    logic                 rd_ack;
    logic                 rd_valid;
    logic [PBW*COL-1:0]   rd_data;
`ifdef PSUM_ACCUM_BUF_STATS_EN
    logic [15:0]          sat_cnt;
    int                   sat_model;
`endif

    int checks = 0;
    int errors = 0;
    int mdl [DEP][COL];
    exp_t exp_q[$];
    logic [PBW*COL-1:0] rd_q[$];

    psum_accum_buf #(
        .col(COL), .psum_bw(PBW), .act_bw(ABW), .depth(DEP), .addr_bw(AW), .qshift(QS)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .clr_i(clr),
        .busy_o(busy),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .in_acc_i(in_acc),
        .in_mask_i(in_mask),
        .in_addr_i(in_addr),
        .in_psum_i(in_psum),
        .out_valid_o(out_valid),
        .out_addr_o(out_addr),
        .out_psum_o(out_psum),
        .out_act_o(out_act),
        .rd_req_i(rd_req),
        .rd_addr_i(rd_addr),
        .rd_ack_o(rd_ack),
        .rd_valid_o(rd_valid),
`ifdef PSUM_ACCUM_BUF_STATS_EN
        .sat_cnt_o(sat_cnt),
`endif
        .rd_data_o(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] row_all(input int v);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < COL; i++) r[i*PBW +: PBW] = 16'(v);
        return r;
    endfunction

    function automatic logic [127:0] model_row(input int a);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < COL; i++) r[i*PBW +: PBW] = 16'(mdl[a][i]);
        return r;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < DEP; r++)
            for (int i = 0; i < COL; i++) mdl[r][i] = 0;
`ifdef PSUM_ACCUM_BUF_STATS_EN
        sat_model = 0;
`endif
    endtask

    // Requests are applied to the model in acceptance order; the DUT must look identical.
    task automatic model_op(input bit acc, input logic [7:0] mask, input int addr, input logic [127:0] ps);
        exp_t e;
        int nsat;
        nsat = 0;
        e.addr = 4'(addr);
        e.psum = '0;
        e.act  = '0;
        for (int i = 0; i < COL; i++) begin
            int nv, s, c, a;
            nv = int'($signed(ps[i*PBW +: PBW]));
            s  = (acc ? mdl[addr][i] : 0) + nv;
            c  = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
            if (mask[i]) begin
                if (c != s) nsat++;
                mdl[addr][i] = c;
            end
            a = mdl[addr][i] >>> QS;
            if (a < 0) a = 0;
            if (a > 15) a = 15;
            e.psum[i*PBW +: PBW] = 16'(mdl[addr][i]);
            e.act[i*ABW +: ABW]  = 4'(a);
        end
`ifdef PSUM_ACCUM_BUF_STATS_EN
        sat_model = sat_model + nsat;
        if (sat_model > 65535) sat_model = 65535;
`endif
        exp_q.push_back(e);
    endtask

    // One clock of stimulus, applied at a negedge.
    task automatic cyc(input bit v, input bit acc, input logic [7:0] mask, input int addr,
                       input logic [127:0] ps, input bit rq, input int ra, input bit cl);
        bit rdy, exp_ack;
        in_valid = v;
        in_acc   = acc;
        in_mask  = mask;
        in_addr  = addr[3:0];
        in_psum  = ps;
        rd_req   = rq;
        rd_addr  = ra[3:0];
        clr      = cl;
        #1;
        rdy = in_ready;
        exp_ack = rdy && rq && !v;
        if (rq) chk("rd_ack", 128'(rd_ack), 128'(exp_ack));
        if (v && rdy) model_op(acc, mask, addr, ps);
        if (exp_ack) rd_q.push_back(model_row(ra));
        if (cl && !v && rdy) model_clear();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 8'h00, 0, '0, 1'b0, 0, 1'b0);
    endtask

    task automatic measure_sweep();
        int cnt, rdy_hi, guard;
        cnt = 0; rdy_hi = 0; guard = 0;
        clr = 1'b0; in_valid = 1'b0; rd_req = 1'b0;
        #1;
        while (busy && guard < 100) begin
            if (in_ready) rdy_hi++;
            cnt++;
            guard++;
            @(negedge clk);
            #1;
        end
        chk("busy_cycles", 128'(cnt), 128'(16));
        chk("in_ready_during_clear", 128'(rdy_hi), 128'(0));
        @(negedge clk);
    endtask

    // Assert reset at a negedge, hold it, check zeroed outputs, release and time the sweep.
    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0; rd_req = 1'b0; clr = 1'b0;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_psum", 128'(out_psum), 128'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        rd_q.delete();
        model_clear();
        chk("rst_busy", 128'(busy), 128'(1));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_addr", 128'(out_addr), 128'(0));
        chk("rst_out_act", 128'(out_act), 128'(0));
        chk("rst_rd_valid", 128'(rd_valid), 128'(0));
        chk("rst_rd_data", 128'(rd_data), 128'(0));
`ifdef PSUM_ACCUM_BUF_STATS_EN
        chk("rst_sat_cnt", 128'(sat_cnt), 128'(0));
`endif
        reset = 1'b0;
        measure_sweep();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_unexpected: got out_valid addr %0d expected no output", out_addr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_addr", 128'(out_addr), 128'(e.addr));
                    chk("out_psum", out_psum, e.psum);
                    chk("out_act", 128'(out_act), 128'(e.act));
                end
            end
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got rd_valid expected none");
                end else begin
                    logic [127:0] r;
                    r = rd_q.pop_front();
                    chk("rd_data", rd_data, r);
                end
            end
        end
    end

    initial begin
        model_clear();
        @(negedge clk);
        do_reset();

        // Fresh array reads as zero
        cyc(1'b0, 1'b0, 8'h00, 0, '0, 1'b1, 5, 1'b0);
        idle(2);

        // Back-to-back accumulate on one row exercises forwarding
        cyc(1'b1, 1'b0, 8'hFF, 3, row_all(100), 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b1, 8'hFF, 3, row_all(25), 1'b0, 0, 1'b0);
        idle(3);
        chk("fwd_row3", model_row(3), row_all(125));

        // Saturation in both directions
        cyc(1'b1, 1'b0, 8'hFF, 1, row_all(32000), 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b1, 8'hFF, 1, row_all(1000), 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 8'hFF, 1, row_all(-32000), 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b1, 8'hFF, 1, row_all(-1000), 1'b0, 0, 1'b0);
        idle(3);
`ifdef PSUM_ACCUM_BUF_STATS_EN
        chk("sat_cnt_16", 128'(sat_cnt), 128'(16));
`endif

        // Per-column mask
        cyc(1'b1, 1'b0, 8'hFF, 2, row_all(5), 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b1, 8'h01, 2, row_all(7), 1'b0, 0, 1'b0);
        idle(1);
        cyc(1'b1, 1'b0, 8'h01, 2, row_all(7), 1'b0, 0, 1'b0);
        idle(3);

        // Readout loses to an update, then returns the row that update wrote
        cyc(1'b1, 1'b1, 8'hFF, 6, row_all(9), 1'b1, 6, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 0, '0, 1'b1, 6, 1'b0);
        idle(3);

        // Randomised mix on a few hot rows
        for (int n = 0; n < 400; n++) begin
            bit v, acc, rq;
            logic [7:0] mask;
            logic [127:0] ps;
            int addr, ra;
            v    = ($urandom % 4) != 0;
            acc  = $urandom % 2;
            mask = ($urandom % 3 == 0) ? 8'hFF : 8'($urandom);
            addr = ($urandom % 4 == 0) ? int'($urandom % 16) : int'($urandom % 3);
            for (int i = 0; i < COL; i++)
                ps[i*PBW +: PBW] = ($urandom % 2) ? 16'($urandom) : 16'($urandom_range(0, 600) - 300);
            rq = ($urandom % 3) == 0;
            ra = ($urandom % 2) ? addr : int'($urandom % 16);
            cyc(v, acc, mask, addr, ps, rq, ra, 1'b0);
        end
        idle(3);
`ifdef PSUM_ACCUM_BUF_STATS_EN
        chk("sat_cnt_rand", 128'(sat_cnt), 128'(sat_model));
`endif

        // clr alongside a request is ignored; held into an idle cycle it sweeps
        cyc(1'b1, 1'b1, 8'hFF, 4, row_all(11), 1'b0, 0, 1'b1);
        chk("clr_ignored_busy", 128'(busy), 128'(0));
        cyc(1'b0, 1'b0, 8'h00, 0, '0, 1'b0, 0, 1'b1);
        measure_sweep();
        for (int r = 0; r < DEP; r++) cyc(1'b0, 1'b0, 8'h00, 0, '0, 1'b1, r, 1'b0);
        idle(2);

        // Reset during a sweep
        cyc(1'b0, 1'b0, 8'h00, 0, '0, 1'b0, 0, 1'b1);
        idle(5);
        do_reset();

        // Reset while streaming
        for (int n = 0; n < 5; n++) cyc(1'b1, 1'b0, 8'hFF, n, row_all(300 + n), 1'b0, 0, 1'b0);
        do_reset();
        cyc(1'b0, 1'b0, 8'h00, 0, '0, 1'b1, 2, 1'b0);
        idle(3);

        chk("out_queue_empty", 128'(exp_q.size()), 128'(0));
        chk("rd_queue_empty", 128'(rd_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
